// File: rtl/mem_arbiter_if.sv
// Bundle of the I-cache, D-cache and unified memory signals seen by mem_arbiter.
// The master modport is the arbiter's view (it masters the memory port and
// answers both caches); the slave modport is the view of the surrounding
// caches and memory.
interface mem_arbiter_if #(
    parameter int ADDR_W = 28,
    parameter int DATA_W = 128
);
    logic              i_read;
    logic              i_write;
    logic [ADDR_W-1:0] i_addr;
    logic [DATA_W-1:0] i_wdata;
    logic [DATA_W-1:0] i_rdata;
    logic              i_ready;

    logic              d_read;
    logic              d_write;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [DATA_W-1:0] d_rdata;
    logic              d_ready;

    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ready;

    modport master (
        input  i_read, i_write, i_addr, i_wdata,
        output i_rdata, i_ready,
        input  d_read, d_write, d_addr, d_wdata,
        output d_rdata, d_ready,
        output mem_read, mem_write, mem_addr, mem_wdata,
        input  mem_rdata, mem_ready
    );

    modport slave (
        output i_read, i_write, i_addr, i_wdata,
        input  i_rdata, i_ready,
        output d_read, d_write, d_addr, d_wdata,
        input  d_rdata, d_ready,
        input  mem_read, mem_write, mem_addr, mem_wdata,
        output mem_rdata, mem_ready
    );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one slow line-wide memory port between the I-cache and
// the D-cache. One transaction in flight; all memory-side outputs registered.
// Sequence per transaction: IDLE (grant) -> BUSY (wait mem_ready) -> DONE
// (one dead cycle so a stale, still-held request is not re-granted) -> IDLE.
// Build option: define MEM_ARB_RR_EN for round-robin arbitration on contention;
// left undefined, the D-cache has fixed priority.
module mem_arbiter #(
    parameter int ADDR_W = 28,
    parameter int DATA_W = 128
) (
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.master bus
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    typedef enum logic {OWNER_D = 1'b0, OWNER_I = 1'b1} owner_t;

    state_t            state_q,     state_d;
    owner_t            owner_q,     owner_d;
    logic              mem_read_q,  mem_read_d;
    logic              mem_write_q, mem_write_d;
    logic [ADDR_W-1:0] mem_addr_q,  mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0] i_rdata_q,   i_rdata_d;
    logic [DATA_W-1:0] d_rdata_q,   d_rdata_d;
    logic              i_ready_q,   i_ready_d;
    logic              d_ready_q,   d_ready_d;

    logic i_pend;
    logic d_pend;
    logic grant_i;

    // Decide which requester would win if a grant were made this cycle.
    always_comb begin
        i_pend = bus.i_read | bus.i_write;
        d_pend = bus.d_read | bus.d_write;
`ifdef MEM_ARB_RR_EN
        // On contention the cache that did not own the previous transaction wins.
        grant_i = i_pend && (!d_pend || owner_q == OWNER_D);
`else
        grant_i = i_pend && !d_pend;
`endif
    end

    // Next-state and registered-output computation for the transaction sequencer.
    always_comb begin
        // NOTE: every signal gets its hold value first so no path leaves it unassigned (no latches).
        state_d     = state_q;
        owner_d     = owner_q;
        mem_read_d  = mem_read_q;
        mem_write_d = mem_write_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        i_rdata_d   = i_rdata_q;
        d_rdata_d   = d_rdata_q;
        i_ready_d   = 1'b0;
        d_ready_d   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (i_pend || d_pend) begin
                    state_d = BUSY;
                    if (grant_i) begin
                        owner_d     = OWNER_I;
                        mem_write_d = bus.i_write;   // write wins over read
                        mem_read_d  = !bus.i_write;
                        mem_addr_d  = bus.i_addr;
                        mem_wdata_d = bus.i_wdata;
                    end else begin
                        owner_d     = OWNER_D;
                        mem_write_d = bus.d_write;
                        mem_read_d  = !bus.d_write;
                        mem_addr_d  = bus.d_addr;
                        mem_wdata_d = bus.d_wdata;
                    end
                end
            end
            BUSY: begin
                if (bus.mem_ready) begin
                    state_d     = DONE;
                    mem_read_d  = 1'b0;
                    mem_write_d = 1'b0;
                    if (owner_q == OWNER_I) begin
                        i_ready_d = 1'b1;
                        if (mem_read_q) i_rdata_d = bus.mem_rdata;
                    end else begin
                        d_ready_d = 1'b1;
                        if (mem_read_q) d_rdata_d = bus.mem_rdata;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: the wide data registers are reset too, because every output must read 0 after reset.
        if (rst) begin
            state_q     <= IDLE;
            owner_q     <= OWNER_D;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            i_rdata_q   <= '0;
            d_rdata_q   <= '0;
            i_ready_q   <= 1'b0;
            d_ready_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so all flops update from the same pre-edge values.
            state_q     <= state_d;
            owner_q     <= owner_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            i_rdata_q   <= i_rdata_d;
            d_rdata_q   <= d_rdata_d;
            i_ready_q   <= i_ready_d;
            d_ready_q   <= d_ready_d;
        end
    end

    assign bus.mem_read  = mem_read_q;
    assign bus.mem_write = mem_write_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.i_rdata   = i_rdata_q;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.i_ready   = i_ready_q;
    assign bus.d_ready   = d_ready_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter. Expected memory transactions are queued
// when requests are driven and popped when the arbiter raises a memory strobe.
module tb_mem_arbiter;
    localparam int AW = 28;
    localparam int DW = 128;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        bit          own_i;
        bit          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] rdata;
    } txn_t;

    txn_t          sb[$];
    int            n_cmp = 0;
    int            n_err = 0;
    logic [DW-1:0] exp_i_rdata = '0;
    logic [DW-1:0] exp_d_rdata = '0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DW-1:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic drive(input bit own_i, input bit wr, input logic [AW-1:0] addr,
                         input logic [DW-1:0] wdata);
        if (own_i) begin
            bus.i_read = !wr; bus.i_write = wr; bus.i_addr = addr; bus.i_wdata = wdata;
        end else begin
            bus.d_read = !wr; bus.d_write = wr; bus.d_addr = addr; bus.d_wdata = wdata;
        end
    endtask

    task automatic drop(input bit own_i);
        if (own_i) begin bus.i_read = 1'b0; bus.i_write = 1'b0; end
        else       begin bus.d_read = 1'b0; bus.d_write = 1'b0; end
    endtask

    task automatic push(input bit own_i, input bit wr, input logic [AW-1:0] addr,
                        input logic [DW-1:0] wdata, input logic [DW-1:0] rdata);
        txn_t t;
        t.own_i = own_i; t.wr = wr; t.addr = addr; t.wdata = wdata; t.rdata = rdata;
        sb.push_back(t);
    endtask

    // Serve one memory transaction: check the strobe against the scoreboard,
    // answer after lat cycles, then check the ready pulse, rdata and DONE gap.
    task automatic run_txn(input string name, input int lat, input bit stale);
        txn_t e;
        int   n = 0;
        while (!(bus.mem_read || bus.mem_write) && n < 50) begin tick(); n++; end
        n_cmp++;
        if (!(bus.mem_read || bus.mem_write)) begin
            n_err++; $display("FAIL %s strobe: none within 50 cycles, required one", name);
            return;
        end
        n_cmp++;
        if (sb.size() == 0) begin
            n_err++; $display("FAIL %s scoreboard: strobe with no queued transaction", name);
            return;
        end
        e = sb.pop_front();
        n_cmp++;
        if (bus.mem_write !== e.wr || bus.mem_read !== !e.wr || bus.mem_addr !== e.addr) begin
            n_err++;
            $display("FAIL %s request: got rd=%b wr=%b addr=%h, required rd=%b wr=%b addr=%h",
                     name, bus.mem_read, bus.mem_write, bus.mem_addr, !e.wr, e.wr, e.addr);
        end
        if (e.wr) begin
            n_cmp++;
            if (bus.mem_wdata !== e.wdata) begin
                n_err++; $display("FAIL %s wdata: got %h required %h", name, bus.mem_wdata, e.wdata);
            end
        end
        repeat (lat - 1) tick();
        n_cmp++;
        if (bus.mem_read !== !e.wr || bus.mem_write !== e.wr || bus.mem_addr !== e.addr ||
            bus.i_ready !== 1'b0 || bus.d_ready !== 1'b0) begin
            n_err++;
            $display("FAIL %s hold: got rd=%b wr=%b addr=%h ir=%b dr=%b before mem_ready",
                     name, bus.mem_read, bus.mem_write, bus.mem_addr, bus.i_ready, bus.d_ready);
        end
        bus.mem_ready = 1'b1;
        bus.mem_rdata = e.rdata;
        tick();
        bus.mem_ready = 1'b0;
        bus.mem_rdata = rnd128();
        if (!e.wr) begin
            if (e.own_i) exp_i_rdata = e.rdata;
            else         exp_d_rdata = e.rdata;
        end
        n_cmp++;
        if (bus.i_ready !== e.own_i || bus.d_ready !== !e.own_i) begin
            n_err++; $display("FAIL %s ready: got i=%b d=%b, required i=%b d=%b",
                              name, bus.i_ready, bus.d_ready, e.own_i, !e.own_i);
        end
        n_cmp++;
        if (bus.mem_read !== 1'b0 || bus.mem_write !== 1'b0) begin
            n_err++; $display("FAIL %s strobe clear: got rd=%b wr=%b, required 0",
                              name, bus.mem_read, bus.mem_write);
        end
        n_cmp++;
        if (bus.i_rdata !== exp_i_rdata || bus.d_rdata !== exp_d_rdata) begin
            n_err++; $display("FAIL %s rdata: got i=%h d=%h, required i=%h d=%h",
                              name, bus.i_rdata, bus.d_rdata, exp_i_rdata, exp_d_rdata);
        end
        if (!stale) drop(e.own_i);
        tick();
        if (stale) drop(e.own_i);
        n_cmp++;
        if (bus.i_ready !== 1'b0 || bus.d_ready !== 1'b0 || bus.mem_read !== 1'b0 ||
            bus.mem_write !== 1'b0) begin
            n_err++; $display("FAIL %s done cycle: got ir=%b dr=%b rd=%b wr=%b, required all 0",
                              name, bus.i_ready, bus.d_ready, bus.mem_read, bus.mem_write);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        n_cmp++;
        if ({bus.mem_read, bus.mem_write, bus.i_ready, bus.d_ready} !== 4'b0 ||
            bus.mem_addr !== '0 || bus.mem_wdata !== '0 || bus.i_rdata !== '0 ||
            bus.d_rdata !== '0) begin
            n_err++; $display("FAIL reset outputs: rd=%b wr=%b ir=%b dr=%b addr=%h, required all 0",
                              bus.mem_read, bus.mem_write, bus.i_ready, bus.d_ready, bus.mem_addr);
        end
        rst = 1'b0;
        tick();
        // A stray mem_ready while idle must not produce a ready pulse or strobe.
        bus.mem_ready = 1'b1;
        tick();
        bus.mem_ready = 1'b0;
        tick();
        n_cmp++;
        if ({bus.mem_read, bus.mem_write, bus.i_ready, bus.d_ready} !== 4'b0) begin
            n_err++; $display("FAIL idle mem_ready: rd=%b wr=%b ir=%b dr=%b, required all 0",
                              bus.mem_read, bus.mem_write, bus.i_ready, bus.d_ready);
        end
    endtask

    task automatic test_i_read();
        push(1'b1, 1'b0, 28'h0000010, '0, {16{8'hA5}});
        drive(1'b1, 1'b0, 28'h0000010, '0);
        tick();
        n_cmp++;
        if (bus.mem_read !== 1'b1) begin
            n_err++; $display("FAIL i_read latency: mem_read=%b one cycle after request, required 1",
                              bus.mem_read);
        end
        run_txn("i_read", 4, 1'b0);
    endtask

    task automatic test_d_write();
        logic [DW-1:0] wd = 128'h1234_5678_9ABC_DEF0_0FED_CBA9_8765_4321;
        push(1'b0, 1'b1, 28'h0000200, wd, rnd128());
        drive(1'b0, 1'b1, 28'h0000200, wd);
        run_txn("d_write", 3, 1'b0);
    endtask

    task automatic test_rw_both();
        logic [DW-1:0] wd = rnd128();
        push(1'b0, 1'b1, 28'h0ABCDEF, wd, rnd128());
        drive(1'b0, 1'b1, 28'h0ABCDEF, wd);
        bus.d_read = 1'b1;
        run_txn("d_read_write", 2, 1'b0);
    endtask

    task automatic test_contention();
        bit first_i;
`ifdef MEM_ARB_RR_EN
        first_i = 1'b1;
`else
        first_i = 1'b0;
`endif
        push(first_i,  1'b0, first_i ? 28'h0000100 : 28'h0000300, '0, rnd128());
        push(!first_i, 1'b0, first_i ? 28'h0000300 : 28'h0000100, '0, rnd128());
        drive(1'b1, 1'b0, 28'h0000100, '0);
        drive(1'b0, 1'b0, 28'h0000300, '0);
        run_txn("contend_first", 3, 1'b0);
        tick();
        n_cmp++;
        if (bus.mem_read !== 1'b1) begin
            n_err++; $display("FAIL contend gap: mem_read=%b after one dead cycle, required 1",
                              bus.mem_read);
        end
        run_txn("contend_second", 2, 1'b0);
    endtask

    task automatic test_stale();
        bit seen = 1'b0;
        push(1'b1, 1'b0, 28'h0000440, '0, rnd128());
        drive(1'b1, 1'b0, 28'h0000440, '0);
        run_txn("stale_txn", 2, 1'b1);
        for (int k = 0; k < 5; k++) begin
            tick();
            if (bus.mem_read || bus.mem_write) seen = 1'b1;
        end
        n_cmp++;
        if (seen) begin
            n_err++; $display("FAIL stale regrant: strobe seen=%b after stale request, required 0", seen);
        end
    endtask

    task automatic test_reset_busy();
        drive(1'b1, 1'b0, 28'h0000880, '0);
        tick();
        n_cmp++;
        if (bus.mem_read !== 1'b1) begin
            n_err++; $display("FAIL rst_busy start: mem_read=%b, required 1", bus.mem_read);
        end
        repeat (2) tick();
        rst = 1'b1;
        drop(1'b1);
        tick();
        rst = 1'b0;
        exp_i_rdata = '0;
        exp_d_rdata = '0;
        n_cmp++;
        if ({bus.mem_read, bus.mem_write, bus.i_ready, bus.d_ready} !== 4'b0 ||
            bus.mem_addr !== '0 || bus.mem_wdata !== '0 || bus.i_rdata !== '0 ||
            bus.d_rdata !== '0) begin
            n_err++; $display("FAIL rst_busy outputs: rd=%b wr=%b ir=%b dr=%b addr=%h, required all 0",
                              bus.mem_read, bus.mem_write, bus.i_ready, bus.d_ready, bus.mem_addr);
        end
        push(1'b0, 1'b0, 28'h0000990, '0, rnd128());
        drive(1'b0, 1'b0, 28'h0000990, '0);
        run_txn("rst_busy_d_read", 3, 1'b0);
    endtask

`ifdef MEM_ARB_RR_EN
    task automatic test_round_robin();
        drive(1'b1, 1'b0, 28'h0001000, '0);
        drive(1'b0, 1'b0, 28'h0002000, '0);
        for (int k = 0; k < 4; k++) begin
            bit own_i = (k % 2 == 0);
            push(own_i, 1'b0, own_i ? 28'h0001000 : 28'h0002000, '0, rnd128());
            run_txn(own_i ? "rr_i" : "rr_d", 2, 1'b0);
            if (k < 3) drive(own_i, 1'b0, own_i ? 28'h0001000 : 28'h0002000, '0);
        end
        drop(1'b1);
        drop(1'b0);
        for (int k = 0; k < 2; k++) begin
            push(1'b0, 1'b0, 28'h0003000, '0, rnd128());
            drive(1'b0, 1'b0, 28'h0003000, '0);
            run_txn("rr_d_alone", 2, 1'b0);
        end
    endtask
`endif

    initial begin
        bus.i_read = 0; bus.i_write = 0; bus.i_addr = '0; bus.i_wdata = '0;
        bus.d_read = 0; bus.d_write = 0; bus.d_addr = '0; bus.d_wdata = '0;
        bus.mem_rdata = '0; bus.mem_ready = 0;
        test_reset();
        test_i_read();
        test_d_write();
        test_rw_both();
        test_contention();
        test_stale();
        test_reset_busy();
`ifdef MEM_ARB_RR_EN
        test_round_robin();
`endif
        n_cmp++;
        if (sb.size() != 0) begin
            n_err++; $display("FAIL scoreboard drain: %0d transactions left, required 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
